// File: rtl/dma_put_data_to_net_seg.sv
// One-sided put engine: pops put commands, emits a one-beat TCP header, then streams the
// local buffer via DMA in segments of at most MAX_SEG_BYTES, rate-limited by a token bucket.
module dma_put_data_to_net_seg #(
   parameter int DATA_W         = 512,
   parameter int CMD_DEPTH_BITS = 4,
   parameter int MAX_SEG_BYTES  = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [63:0]         dma_base_addr,
   input  logic [15:0]         token_period,
   input  logic [15:0]         token_max,
   input  logic                s_cmd_valid,
   output logic                s_cmd_ready,
   input  logic [111:0]        s_cmd_data,
   output logic                m_dma_cmd_valid,
   input  logic                m_dma_cmd_ready,
   output logic [63:0]         m_dma_cmd_addr,
   output logic [31:0]         m_dma_cmd_len,
   input  logic                s_dma_data_valid,
   output logic                s_dma_data_ready,
   input  logic [DATA_W-1:0]   s_dma_data,
   output logic                m_tx_meta_valid,
   input  logic                m_tx_meta_ready,
   output logic [47:0]         m_tx_meta_data,
   output logic                m_tx_valid,
   input  logic                m_tx_ready,
   output logic                m_tx_last,
   output logic [DATA_W-1:0]   m_tx_data,
   output logic [DATA_W/8-1:0] m_tx_keep,
   output logic                cmd_done,
   output logic [63:0]         bytes_sent,
   output logic [31:0]         seg_cnt
);
   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int BB_BITS    = $clog2(BEAT_BYTES);
   localparam int DEPTH      = 1 << CMD_DEPTH_BITS;
   localparam logic [CMD_DEPTH_BITS:0] FULL_CNT = (CMD_DEPTH_BITS + 1)'(DEPTH);
   localparam logic [31:0] MAX_SEG = 32'(MAX_SEG_BYTES);

   typedef enum logic [2:0] {IDLE, POP, HDR_META, HDR_DATA, SEG_CMD, SEG_META, SEG_DATA, DONE} state_t;

   state_t                    state_q, state_d;
   logic [CMD_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CMD_DEPTH_BITS:0]   count_q, count_d;
   logic [15:0]               session_q, session_d;
   logic [31:0]               local_q, local_d, remote_q, remote_d, length_q, length_d;
   logic [31:0]               offset_q, offset_d, remain_q, remain_d;
   logic [31:0]               seg_len_q, seg_len_d, beat_left_q, beat_left_d;
   logic [63:0]               dma_addr_q, dma_addr_d, bytes_sent_q, bytes_sent_d;
   logic [31:0]               seg_cnt_q, seg_cnt_d;
   logic [15:0]               tokens_q, tokens_d, tok_cyc_q, tok_cyc_d;

   logic [111:0]        fifo_mem [DEPTH];
   logic [111:0]        head;
   logic                push, pop, tok_ok, beat_hs, last_beat, refill;
   logic [BB_BITS-1:0]  seg_rem;
   logic [BEAT_BYTES-1:0] keep_mask;
   logic [DATA_W-1:0]   hdr_data;

   assign s_cmd_ready = ~rst & (count_q != FULL_CNT);
   assign push        = s_cmd_valid & s_cmd_ready;
   assign pop         = (state_q == POP);
   assign head        = fifo_mem[rd_ptr_q];
   assign tok_ok      = (tokens_q != 16'd0) || (token_period == 16'd0);
   assign beat_hs     = (state_q == SEG_DATA) & s_dma_data_valid & m_tx_ready & tok_ok;
   assign last_beat   = (beat_left_q == 32'd1);
   assign refill      = (token_period != 16'd0) && (tok_cyc_q >= token_period - 16'd1);
   assign seg_rem     = seg_len_q[BB_BITS-1:0];

   // NOTE: the command store has no reset; only pointers and count define its contents.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= s_cmd_data;
   end

   always_comb begin
      keep_mask = '0;
      for (int i = 0; i < BEAT_BYTES; i++) keep_mask[i] = (BB_BITS'(i) < seg_rem);
      hdr_data        = '0;
      hdr_data[15:0]  = 16'h5;
      hdr_data[47:16] = length_q;
      hdr_data[79:48] = remote_q;
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no path through this block infers a latch.
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q + CMD_DEPTH_BITS'(push);
      rd_ptr_d     = rd_ptr_q + CMD_DEPTH_BITS'(pop);
      count_d      = count_q;
      session_d    = session_q;
      local_d      = local_q;
      remote_d     = remote_q;
      length_d     = length_q;
      offset_d     = offset_q;
      remain_d     = remain_q;
      seg_len_d    = seg_len_q;
      beat_left_d  = beat_left_q;
      dma_addr_d   = dma_addr_q;
      bytes_sent_d = bytes_sent_q;
      seg_cnt_d    = seg_cnt_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;

      case (state_q)
         IDLE:     if (count_q != '0) state_d = POP;
         POP: begin
            session_d = head[111:96];
            local_d   = head[95:64];
            remote_d  = head[63:32];
            length_d  = head[31:0];
            offset_d  = 32'd0;
            remain_d  = head[31:0];
            state_d   = HDR_META;
         end
         HDR_META: if (m_tx_meta_ready) state_d = HDR_DATA;
         HDR_DATA: if (m_tx_ready) state_d = (remain_q != 32'd0) ? SEG_CMD : DONE;
         SEG_CMD:  if (m_dma_cmd_ready) state_d = SEG_META;
         SEG_META: if (m_tx_meta_ready) begin
            beat_left_d = (seg_len_q + 32'(BEAT_BYTES - 1)) >> BB_BITS;
            state_d     = SEG_DATA;
         end
         SEG_DATA: if (beat_hs) begin
            beat_left_d = beat_left_q - 32'd1;
            if (last_beat) begin
               offset_d     = offset_q + seg_len_q;
               remain_d     = remain_q - seg_len_q;
               seg_cnt_d    = seg_cnt_q + 32'd1;
               bytes_sent_d = bytes_sent_q + {32'd0, seg_len_q};
               state_d      = (remain_d != 32'd0) ? SEG_CMD : DONE;
            end
         end
         default:  state_d = IDLE;
      endcase

      // Segment length and DMA address are fixed on entry so the request stays stable.
      if (state_d == SEG_CMD && state_q != SEG_CMD) begin
         seg_len_d  = (remain_d > MAX_SEG) ? MAX_SEG : remain_d;
         dma_addr_d = dma_base_addr + {32'd0, local_q} + {32'd0, offset_d};
      end

      tok_cyc_d = (token_period == 16'd0 || refill) ? 16'd0 : tok_cyc_q + 16'd1;
      tokens_d  = tokens_q;
      if (refill && !beat_hs && tokens_q < token_max) tokens_d = tokens_q + 16'd1;
      else if (!refill && beat_hs && tokens_q != 16'd0) tokens_d = tokens_q - 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;      wr_ptr_q <= '0;      rd_ptr_q <= '0;       count_q <= '0;
         session_q <= '0;      local_q <= '0;       remote_q <= '0;       length_q <= '0;
         offset_q <= '0;       remain_q <= '0;      seg_len_q <= '0;      beat_left_q <= '0;
         dma_addr_q <= '0;     bytes_sent_q <= '0;  seg_cnt_q <= '0;
         tokens_q <= '0;       tok_cyc_q <= '0;
      end else begin
         state_q <= state_d;   wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
         session_q <= session_d; local_q <= local_d; remote_q <= remote_d; length_q <= length_d;
         offset_q <= offset_d; remain_q <= remain_d; seg_len_q <= seg_len_d; beat_left_q <= beat_left_d;
         dma_addr_q <= dma_addr_d; bytes_sent_q <= bytes_sent_d; seg_cnt_q <= seg_cnt_d;
         tokens_q <= tokens_d; tok_cyc_q <= tok_cyc_d;
      end
   end

   assign m_dma_cmd_valid  = (state_q == SEG_CMD);
   assign m_dma_cmd_addr   = dma_addr_q;
   assign m_dma_cmd_len    = seg_len_q;
   assign m_tx_meta_valid  = (state_q == HDR_META) || (state_q == SEG_META);
   assign m_tx_meta_data   = (state_q == HDR_META) ? {32'(BEAT_BYTES), session_q} :
                             (state_q == SEG_META) ? {seg_len_q, session_q} : 48'd0;
   assign s_dma_data_ready = (state_q == SEG_DATA) & m_tx_ready & tok_ok;
   assign m_tx_valid       = (state_q == HDR_DATA) | ((state_q == SEG_DATA) & s_dma_data_valid & tok_ok);
   assign m_tx_last        = (state_q == HDR_DATA) | ((state_q == SEG_DATA) & last_beat);
   assign m_tx_data        = (state_q == HDR_DATA) ? hdr_data :
                             (state_q == SEG_DATA) ? s_dma_data : '0;
   assign m_tx_keep        = (state_q == HDR_DATA) ? '1 :
                             (state_q != SEG_DATA) ? '0 :
                             (last_beat && seg_rem != '0) ? keep_mask : '1;
   assign cmd_done         = (state_q == DONE);
   assign bytes_sent       = bytes_sent_q;
   assign seg_cnt          = seg_cnt_q;
endmodule

// File: tb/tb_dma_put_data_to_net_seg.sv
// Directed bench for dma_put_data_to_net_seg: command table plus latency, limiter,
// backpressure/FIFO-full and mid-transfer reset sequences against a reference model.
module tb_dma_put_data_to_net_seg;
   localparam int DW = 512;

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   dma_base_addr;
   logic [15:0]   token_period, token_max;
   logic          s_cmd_valid, s_cmd_ready;
   logic [111:0]  s_cmd_data;
   logic          m_dma_cmd_valid, m_dma_cmd_ready;
   logic [63:0]   m_dma_cmd_addr;
   logic [31:0]   m_dma_cmd_len;
   logic          s_dma_data_valid, s_dma_data_ready;
   logic [DW-1:0] s_dma_data;
   logic          m_tx_meta_valid, m_tx_meta_ready;
   logic [47:0]   m_tx_meta_data;
   logic          m_tx_valid, m_tx_ready, m_tx_last;
   logic [DW-1:0] m_tx_data;
   logic [63:0]   m_tx_keep;
   logic          cmd_done;
   logic [63:0]   bytes_sent;
   logic [31:0]   seg_cnt;

   dma_put_data_to_net_seg dut (
      .clk(clk), .rst(rst), .dma_base_addr(dma_base_addr),
      .token_period(token_period), .token_max(token_max),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_data(s_cmd_data),
      .m_dma_cmd_valid(m_dma_cmd_valid), .m_dma_cmd_ready(m_dma_cmd_ready),
      .m_dma_cmd_addr(m_dma_cmd_addr), .m_dma_cmd_len(m_dma_cmd_len),
      .s_dma_data_valid(s_dma_data_valid), .s_dma_data_ready(s_dma_data_ready), .s_dma_data(s_dma_data),
      .m_tx_meta_valid(m_tx_meta_valid), .m_tx_meta_ready(m_tx_meta_ready), .m_tx_meta_data(m_tx_meta_data),
      .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready), .m_tx_last(m_tx_last),
      .m_tx_data(m_tx_data), .m_tx_keep(m_tx_keep),
      .cmd_done(cmd_done), .bytes_sent(bytes_sent), .seg_cnt(seg_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [DW-1:0] data; logic [63:0] keep; logic last; } beat_t;
   typedef struct packed { logic [63:0] addr; logic [31:0] len; } dcmd_t;
   typedef struct {
      logic [15:0] sess; logic [31:0] loc; logic [31:0] rem; logic [31:0] len;
      int segs; logic [63:0] last_keep;
   } vec_t;

   beat_t         exp_tx[$];
   logic [47:0]   exp_meta[$];
   dcmd_t         exp_dma[$];
   logic [DW-1:0] src_q[$];

   int pass_cnt = 0, total_cnt = 0;
   int done_cnt = 0, dma_cnt = 0, dhs_cnt = 0;
   int cyc = 0, last_dhs_cyc = -10, first_dhs_cyc = 0, run = 0, max_run = 0, last_gap = 0;
   logic [63:0] last_keep = '0;
   bit mon_en = 1'b0, bp_en = 1'b0, meta_hold = 1'b0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_item(input string name);
      total_cnt++;
      $display("FAIL %s: got an unexpected item, expected none", name);
   endtask

   function automatic logic [DW-1:0] pat(input logic [63:0] addr, input int b);
      logic [DW-1:0] w;
      for (int j = 0; j < DW / 32; j++)
         w[j*32 +: 32] = (addr[31:0] + 32'(b * 64 + j * 4)) ^ addr[63:32];
      return w;
   endfunction

   // Reference model: expected metadata, DMA requests and TX beats for one command.
   task automatic push_expected(input logic [15:0] sess, input logic [31:0] loc,
                                input logic [31:0] rem, input logic [31:0] len);
      beat_t bt;
      logic [63:0] addr;
      int unsigned off, remain, seg, nb, r;
      exp_meta.push_back({32'd64, sess});
      bt.data = '0;
      bt.data[15:0] = 16'h5; bt.data[47:16] = len; bt.data[79:48] = rem;
      bt.keep = '1; bt.last = 1'b1;
      exp_tx.push_back(bt);
      off = 0; remain = len;
      while (remain != 0) begin
         seg  = (remain > 4096) ? 4096 : remain;
         addr = dma_base_addr + {32'd0, loc} + 64'(off);
         exp_dma.push_back({addr, 32'(seg)});
         exp_meta.push_back({32'(seg), sess});
         nb = (seg + 63) / 64;
         r  = seg % 64;
         for (int b = 0; b < int'(nb); b++) begin
            bt.data = pat(addr, b);
            bt.last = (b == int'(nb) - 1);
            bt.keep = '1;
            if (bt.last && r != 0) begin
               bt.keep = '0;
               for (int k = 0; k < int'(r); k++) bt.keep[k] = 1'b1;
            end
            exp_tx.push_back(bt);
         end
         off += seg; remain -= seg;
      end
   endtask

   // Sink/source driver and monitor: drive at the falling edge, observe handshakes 1 ns later.
   initial begin
      s_dma_data_valid = 1'b0; s_dma_data = '0;
      m_tx_ready = 1'b0; m_tx_meta_ready = 1'b0; m_dma_cmd_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mon_en) begin
            s_dma_data_valid = 1'b0; s_dma_data = '0;
            m_tx_ready = 1'b0; m_tx_meta_ready = 1'b0; m_dma_cmd_ready = 1'b0;
         end else begin
            m_tx_ready      = bp_en ? ($urandom_range(3) != 0) : 1'b1;
            m_tx_meta_ready = meta_hold ? 1'b0 : (bp_en ? ($urandom_range(1) != 0) : 1'b1);
            m_dma_cmd_ready = bp_en ? ($urandom_range(1) != 0) : 1'b1;
            if (src_q.size() > 0 && (s_dma_data_valid || !bp_en || $urandom_range(2) != 0)) begin
               s_dma_data_valid = 1'b1; s_dma_data = src_q[0];
            end else begin
               s_dma_data_valid = 1'b0; s_dma_data = '0;
            end
            #1;
            if (m_tx_meta_valid && m_tx_meta_ready) begin
               if (exp_meta.size() == 0) fail_item("meta");
               else check("meta", DW'(m_tx_meta_data), DW'(exp_meta.pop_front()));
            end
            if (m_tx_valid && m_tx_ready) begin
               last_keep = m_tx_keep;
               if (exp_tx.size() == 0) fail_item("tx_beat");
               else begin
                  beat_t e;
                  e = exp_tx.pop_front();
                  check("tx_data", m_tx_data, e.data);
                  check("tx_keep", DW'(m_tx_keep), DW'(e.keep));
                  check("tx_last", DW'(m_tx_last), DW'(e.last));
               end
            end
            if (m_dma_cmd_valid && m_dma_cmd_ready) begin
               dma_cnt++;
               if (exp_dma.size() == 0) fail_item("dma_cmd");
               else check("dma_cmd", DW'({m_dma_cmd_addr, m_dma_cmd_len}), DW'(exp_dma.pop_front()));
               for (int b = 0; b < (int'(m_dma_cmd_len) + 63) / 64; b++)
                  src_q.push_back(pat(m_dma_cmd_addr, b));
            end
            if (s_dma_data_valid && s_dma_data_ready) begin
               void'(src_q.pop_front());
               if (dhs_cnt == 0) first_dhs_cyc = cyc;
               run = (last_dhs_cyc == cyc - 1) ? run + 1 : 1;
               if (run > max_run) max_run = run;
               last_gap = cyc - last_dhs_cyc;
               last_dhs_cyc = cyc;
               dhs_cnt++;
            end
            if (cmd_done) done_cnt++;
         end
      end
   end

   task automatic send_cmd(input logic [15:0] sess, input logic [31:0] loc,
                           input logic [31:0] rem, input logic [31:0] len);
      int n = 0;
      push_expected(sess, loc, rem, len);
      s_cmd_valid = 1'b1;
      s_cmd_data  = {sess, loc, rem, len};
      while (!s_cmd_ready && n < 5000) begin @(negedge clk); n++; end
      if (n == 5000) check("cmd_accept_timeout", 0, 1);
      @(negedge clk);
      s_cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int tgt, input string name);
      int n = 0;
      while (done_cnt < tgt && n < 20000) begin @(negedge clk); n++; end
      check(name, DW'(done_cnt >= tgt), 1);
      @(negedge clk); #2;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cmd_ready"}, DW'(s_cmd_ready), 0);
      check({tag, "_tx_valid"}, DW'(m_tx_valid), 0);
      check({tag, "_meta_valid"}, DW'(m_tx_meta_valid), 0);
      check({tag, "_dma_valid"}, DW'(m_dma_cmd_valid), 0);
      check({tag, "_dma_ready"}, DW'(s_dma_data_ready), 0);
      check({tag, "_done"}, DW'(cmd_done), 0);
      check({tag, "_bytes"}, DW'(bytes_sent), 0);
      check({tag, "_segs"}, DW'(seg_cnt), 0);
      check({tag, "_tx_data"}, m_tx_data, 0);
      check({tag, "_dma_addr"}, DW'(m_dma_cmd_addr), 0);
   endtask

   vec_t vecs[6];

   initial begin
      logic [63:0] b0;
      logic [31:0] s0;
      int d0, tgt;

      vecs[0] = '{16'd3, 32'h100, 32'h2000, 32'd128,   1, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[1] = '{16'd7, 32'h40,  32'h3000, 32'd10000, 3, 64'h0000_0000_0000_FFFF};
      vecs[2] = '{16'd9, 32'h0,   32'h4000, 32'd0,     0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[3] = '{16'd1, 32'h20,  32'h5000, 32'd65,    1, 64'h0000_0000_0000_0001};
      vecs[4] = '{16'd2, 32'h8,   32'h6000, 32'd4096,  1, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[5] = '{16'd4, 32'h0,   32'h7000, 32'd4097,  2, 64'h0000_0000_0000_0001};

      rst = 1'b1; dma_base_addr = 64'h1_0000_0000; token_period = 16'd0; token_max = 16'd0;
      s_cmd_valid = 1'b0; s_cmd_data = '0;
      repeat (3) @(negedge clk);
      #2 check_idle_outputs("reset");
      rst = 1'b0; mon_en = 1'b1;
      @(negedge clk); #2;
      check("post_reset_cmd_ready", DW'(s_cmd_ready), 1);

      // Handshake to header metadata: 3 cycles.
      tgt = done_cnt + 1;
      push_expected(16'd5, 32'h0, 32'h8000, 32'd0);
      s_cmd_valid = 1'b1; s_cmd_data = {16'd5, 32'h0, 32'h8000, 32'd0};
      @(negedge clk); s_cmd_valid = 1'b0; #2;
      check("lat_cycle1_meta", DW'(m_tx_meta_valid), 0);
      @(negedge clk); #2;
      check("lat_cycle2_meta", DW'(m_tx_meta_valid), 0);
      @(negedge clk); #2;
      check("lat_cycle3_meta", DW'(m_tx_meta_valid), 1);
      wait_done(tgt, "lat_done");

      for (int i = 0; i < 6; i++) begin
         b0 = bytes_sent; s0 = seg_cnt; d0 = dma_cnt; tgt = done_cnt + 1;
         send_cmd(vecs[i].sess, vecs[i].loc, vecs[i].rem, vecs[i].len);
         wait_done(tgt, $sformatf("vec%0d_done", i));
         check($sformatf("vec%0d_bytes", i), DW'(bytes_sent - b0), DW'(vecs[i].len));
         check($sformatf("vec%0d_segcnt", i), DW'(seg_cnt - s0), DW'(vecs[i].segs));
         check($sformatf("vec%0d_dmacnt", i), DW'(dma_cnt - d0), DW'(vecs[i].segs));
         check($sformatf("vec%0d_lastkeep", i), DW'(last_keep), DW'(vecs[i].last_keep));
         check($sformatf("vec%0d_drained", i), DW'(exp_tx.size() + exp_meta.size() + exp_dma.size()), 0);
      end

      // Token bucket: period 4, cap 2, 8 beats with every sink ready.
      token_period = 16'd4; token_max = 16'd2;
      dhs_cnt = 0; max_run = 0; run = 0; last_dhs_cyc = -10;
      tgt = done_cnt + 1;
      send_cmd(16'd6, 32'h200, 32'h9000, 32'd512);
      wait_done(tgt, "tok_done");
      check("tok_beats", DW'(dhs_cnt), 8);
      check("tok_max_run_le2", DW'(max_run <= 2), 1);
      check("tok_steady_gap", DW'(last_gap), 4);
      check("tok_span_ge20", DW'((last_dhs_cyc - first_dhs_cyc) >= 20), 1);
      token_period = 16'd0;

      // 17 commands with the first stalled in its header: FIFO fills, then random backpressure.
      meta_hold = 1'b1; bp_en = 1'b1;
      tgt = done_cnt + 17;
      for (int i = 0; i < 17; i++)
         send_cmd(16'(i + 16), 32'(i * 64), 32'(32'h9000 + i), 32'((i * 157) % 700));
      #2 check("fifo_full_ready_low", DW'(s_cmd_ready), 0);
      meta_hold = 1'b0;
      wait_done(tgt, "bp_all_done");
      check("bp_drained", DW'(exp_tx.size() + exp_meta.size() + exp_dma.size()), 0);
      bp_en = 1'b0;

      // Reset in the middle of a segment's data phase.
      dhs_cnt = 0;
      send_cmd(16'd11, 32'h0, 32'hA000, 32'd8192);
      begin
         int n = 0;
         while (dhs_cnt < 10 && n < 5000) begin @(negedge clk); n++; end
         check("rst_reach_seg_data", DW'(dhs_cnt >= 10), 1);
      end
      @(posedge clk); #3;
      rst = 1'b1; mon_en = 1'b0;
      exp_tx.delete(); exp_meta.delete(); exp_dma.delete(); src_q.delete();
      #1 check_idle_outputs("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b0; mon_en = 1'b1;
      @(negedge clk); #2;
      tgt = done_cnt + 1;
      send_cmd(16'd12, 32'h80, 32'hB000, 32'd200);
      wait_done(tgt, "after_rst_done");
      check("after_rst_bytes", DW'(bytes_sent), 200);
      check("after_rst_segs", DW'(seg_cnt), 1);
      check("after_rst_drained", DW'(exp_tx.size() + exp_meta.size() + exp_dma.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/dma_put_data_to_net_seg.md
# dma_put_data_to_net_seg

Multi-segment successor of the one-sided put engine: pops put commands (session, local address, remote address, length), sends a one-beat control header to the TCP stack, then streams the local buffer from host memory via DMA. Payloads larger than `MAX_SEG_BYTES` are split into independent DMA-read/TCP-send segments. Beats are rate-limited by a token bucket. The block sits between the control-register command path and the TCP TX interface in the oneside datapath.

## Interface
- `DATA_W`, 512, data beat width in bits; `BEAT_BYTES` = `DATA_W`/8.
- `CMD_DEPTH_BITS`, 4, command FIFO depth = 2^`CMD_DEPTH_BITS`.
- `MAX_SEG_BYTES`, 4096, maximum bytes per segment; must be a multiple of `BEAT_BYTES`.
- `clk` in 1 — the single clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `dma_base_addr` in 64 — added to every DMA read address.
- `token_period` in 16 — cycles per token; 0 disables the limiter.
- `token_max` in 16 — token bucket cap.
- `s_cmd_valid` / `s_cmd_ready` in/out 1 — command handshake.
- `s_cmd_data` in 112 — {session[111:96], local_addr[95:64], remote_addr[63:32], length[31:0]}.
- `m_dma_cmd_valid` / `m_dma_cmd_ready` out/in 1 — DMA read request handshake.
- `m_dma_cmd_addr` out 64 — DMA read address.
- `m_dma_cmd_len` out 32 — DMA read length in bytes.
- `s_dma_data_valid` / `s_dma_data_ready` in/out 1 — DMA read data handshake.
- `s_dma_data` in `DATA_W` — DMA read data.
- `m_tx_meta_valid` / `m_tx_meta_ready` out/in 1 — TCP TX metadata handshake.
- `m_tx_meta_data` out 48 — {length[47:16], session[15:0]}.
- `m_tx_valid` / `m_tx_ready` / `m_tx_last` out/in/out 1 — TCP TX data handshake and end-of-segment flag.
- `m_tx_data` out `DATA_W` — TCP TX data.
- `m_tx_keep` out `DATA_W`/8 — TCP TX byte enables.
- `cmd_done` out 1 — one-cycle pulse when a command completes.
- `bytes_sent` out 64 — running count of payload bytes sent.
- `seg_cnt` out 32 — running count of segments sent.

## Operation
- Command FIFO: `s_cmd_ready` = not full. Handshakes write the FIFO. The pop is registered; the head is latched in POP.
- FSM states: IDLE, POP, HDR_META, HDR_DATA, SEG_CMD, SEG_META, SEG_DATA, DONE.
- IDLE → POP when the FIFO is non-empty.
- POP → HDR_META: latch the command fields; set `offset` = 0 and `remain` = length.
- HDR_META: `m_tx_meta_valid` = 1 with length = `BEAT_BYTES`. On handshake → HDR_DATA.
- HDR_DATA: `m_tx_valid` = 1, `m_tx_last` = 1, keep = all ones. Data = {zero pad, remote_addr, length, 16'h5}, with 16'h5 in bits [15:0]. On handshake → SEG_CMD if `remain` ≠ 0, else DONE.
- SEG_CMD: `seg_len` = min(`remain`, `MAX_SEG_BYTES`). Present addr = `dma_base_addr` + local_addr + `offset` (64-bit add, zero-extend) and len = `seg_len`. On handshake → SEG_META.
- SEG_META: present metadata {`seg_len`, session}. On handshake → SEG_DATA; load `beat_left` = ceil(`seg_len`/`BEAT_BYTES`).
- SEG_DATA: pass-through, `m_tx_valid` = `s_dma_data_valid` & `tok_ok`; `s_dma_data_ready` = `m_tx_ready` & `tok_ok`.
  - `m_tx_last` = (`beat_left` == 1).
  - keep is all ones, except on the last beat when `seg_len` mod `BEAT_BYTES` ≠ 0: low (`seg_len` mod `BEAT_BYTES`) bits set.
  - Each beat decrements `beat_left`. On the last beat: `offset` += `seg_len`, `remain` -= `seg_len`, `seg_cnt`++, `bytes_sent` += `seg_len`; → SEG_CMD if the new `remain` ≠ 0, else DONE.
- DONE: pulse `cmd_done` → IDLE.
- Token bucket:
  - A cycle counter wraps at `token_period`−1; on wrap, `tokens`++ unless `tokens` == `token_max`.
  - Each SEG_DATA beat handshake consumes 1 token. A same-cycle refill and consume leaves `tokens` unchanged.
  - `tok_ok` = (`tokens` ≠ 0) or (`token_period` == 0).
  - Tokens accrue in every state.
- Length 0: header only, no DMA command, `seg_cnt` unchanged.
- `s_dma_data_ready` is 0 outside SEG_DATA. `m_tx_*` valid is 0 outside HDR_DATA and SEG_DATA.

## Timing
- Reset (async assert, sync deassert):
  - state = IDLE; FIFO empty.
  - all valid/ready outputs = 0, except `s_cmd_ready` = 1 once reset is released.
  - `cmd_done` = 0; `bytes_sent` = 0; `seg_cnt` = 0; `tokens` = 0.
  - `m_*` data outputs = 0.
- Reset mid-transfer aborts immediately; a partially sent segment is not completed.
- Minimum latency with all sinks ready and the limiter off:
  - `s_cmd` handshake to HDR metadata valid: 3 cycles.
  - One cycle each for HDR_META, HDR_DATA, SEG_CMD, SEG_META.
  - Data beats at 1 beat/cycle.
- Valid, once asserted, holds with stable data/addr until the handshake. The SEG_DATA pass-through inherits the source's stability.
- The limiter gates both valid and ready together, so a beat is never half-transferred.

## Test plan
- Limiter off, 1 cmd {session 3, local 0x100, remote 0x2000, len 128}, base 0x1_0000_0000 → header beat [15:0] = 5, remote 0x2000, len 128; DMA addr 0x1_0000_0100, len 128; metadata {128, 3}; 2 beats, last on the 2nd; `cmd_done` pulse; `bytes_sent` = 128.
- len 10000, `MAX_SEG_BYTES` 4096 → 3 segments of 4096/4096/1808 at offsets 0/4096/8192. Final beat keep = 2^16−1 (1808 mod 64 = 16). `seg_cnt` = 3.
- len 0 → header only, no DMA command, `cmd_done`.
- `token_period` 4, `token_max` 2, len 512 with all sinks ready → steady state 1 beat per 4 cycles; never more than 2 back-to-back beats.
- Randomized `m_tx_ready`/`m_tx_meta_ready`/`s_dma_data_valid` backpressure, 16 queued commands (FIFO full → `s_cmd_ready` = 0) → byte-exact data match, ordering preserved.
- Assert `rst` mid-SEG_DATA → all outputs return to reset values asynchronously; a subsequent command completes normally.
